// File: rtl/pp_pkg.sv
// Shared definitions for the packet parser: FSM states, header byte offsets
// and default SOP / CRC polynomial values.
package pp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdHdr0,
        StRdHdr1,
        StRdData,
        StRdCrc,
        StDone
    } pp_state_e;

    localparam logic [31:0] HDR0_OFS = 32'd0;
    localparam logic [31:0] HDR1_OFS = 32'd1;
    localparam logic [31:0] DATA_OFS = 32'd2;

    localparam logic [3:0] SOP_VAL_DEF  = 4'hA;
    localparam logic [7:0] CRC_POLY_DEF = 8'h07;

endpackage

// File: rtl/crc8_byte_step.sv
// One-byte CRC-8 update: MSB-first, no reflection, no final XOR.
module crc8_byte_step
    import pp_pkg::*;
#(
    parameter logic [7:0] CRC_POLY = CRC_POLY_DEF
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/packet_parser.sv
// Streams a packet out of source memory one byte per cycle, copies the data
// bytes to destination memory and checks the SOP nibble and trailing CRC-8.
module packet_parser
    import pp_pkg::*;
#(
    parameter logic [3:0] SOP_VAL  = SOP_VAL_DEF,
    parameter logic [7:0] CRC_POLY = CRC_POLY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pp_start,
    input  logic [31:0] pp_addr_in,
    input  logic [31:0] pp_addr_out,
    input  logic        pp_crc_chk_en,
    output logic [31:0] src_addr,
    input  logic [31:0] src_data_o,
    output logic [31:0] dst_addr,
    output logic [31:0] dst_data_i,
    output logic        dst_we,
    output logic        pp_busy,
    output logic        pp_irq,
    output logic [3:0]  pp_pkt_type,
    output logic [3:0]  pp_byte_cnt,
    output logic        pp_sop_err,
    output logic        pp_crc_err,
    output logic [7:0]  pp_crc_calc
);

    pp_state_e   state_q, state_d;
    logic [31:0] in_base_q, in_base_d;
    logic [31:0] out_base_q, out_base_d;
    logic        chk_en_q, chk_en_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  wr_idx_q, wr_idx_d;
    logic        data_pend_q, data_pend_d;
    logic        crc_wait_q, crc_wait_d;
    logic [7:0]  crc_q, crc_d;
    logic [3:0]  pkt_type_q, pkt_type_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic        sop_err_q, sop_err_d;
    logic        crc_err_q, crc_err_d;
    logic [3:0]  cur_bc;
    logic [7:0]  crc_next;
    logic [7:0]  rd_byte;
    logic        unused_src_hi;

    assign rd_byte       = src_data_o[7:0];
    assign unused_src_hi = ^src_data_o[31:8];

    crc8_byte_step #(
        .CRC_POLY(CRC_POLY)
    ) u_crc_step (
        .crc_in (crc_q),
        .data_in(rd_byte),
        .crc_out(crc_next)
    );

    always_comb begin
        state_d     = state_q;
        in_base_d   = in_base_q;
        out_base_d  = out_base_q;
        chk_en_d    = chk_en_q;
        cnt_d       = cnt_q;
        wr_idx_d    = wr_idx_q;
        data_pend_d = 1'b0;
        crc_wait_d  = crc_wait_q;
        crc_d       = crc_q;
        pkt_type_d  = pkt_type_q;
        byte_cnt_d  = byte_cnt_q;
        sop_err_d   = sop_err_q;
        crc_err_d   = crc_err_q;
        cur_bc      = byte_cnt_q;
        src_addr    = 32'd0;

        // A data byte read last cycle arrives now: write it and fold it into the CRC.
        dst_we     = data_pend_q;
        dst_addr   = data_pend_q ? (out_base_q + {28'd0, wr_idx_q}) : 32'd0;
        dst_data_i = data_pend_q ? {24'd0, rd_byte} : 32'd0;
        if (data_pend_q) begin
            crc_d    = crc_next;
            wr_idx_d = wr_idx_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (pp_start) begin
                    in_base_d  = pp_addr_in;
                    out_base_d = pp_addr_out;
                    chk_en_d   = pp_crc_chk_en;
                    cnt_d      = 4'd0;
                    wr_idx_d   = 4'd0;
                    crc_wait_d = 1'b0;
                    crc_d      = 8'h00;
                    pkt_type_d = 4'd0;
                    byte_cnt_d = 4'd0;
                    sop_err_d  = 1'b0;
                    crc_err_d  = 1'b0;
                    state_d    = StRdHdr0;
                end
            end
            StRdHdr0: begin
                src_addr = in_base_q + HDR0_OFS;
                state_d  = StRdHdr1;
            end
            StRdHdr1: begin
                src_addr   = in_base_q + HDR1_OFS;
                pkt_type_d = rd_byte[3:0];
                sop_err_d  = (rd_byte[7:4] != SOP_VAL);
                state_d    = StRdData;
            end
            StRdData: begin
                // Header byte 1 is only on the bus during the first data-read cycle.
                if (cnt_q == 4'd0) begin
                    cur_bc     = rd_byte[3:0];
                    byte_cnt_d = rd_byte[3:0];
                end
                src_addr    = in_base_q + DATA_OFS + {28'd0, cnt_q};
                data_pend_d = 1'b1;
                if (cnt_q == cur_bc) begin
                    state_d = StRdCrc;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRdCrc: begin
                if (!crc_wait_q) begin
                    src_addr   = in_base_q + DATA_OFS + {28'd0, byte_cnt_q} + 32'd1;
                    crc_wait_d = 1'b1;
                end else begin
                    crc_err_d  = chk_en_q & (rd_byte != crc_q);
                    crc_wait_d = 1'b0;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            in_base_q   <= 32'd0;
            out_base_q  <= 32'd0;
            chk_en_q    <= 1'b0;
            cnt_q       <= 4'd0;
            wr_idx_q    <= 4'd0;
            data_pend_q <= 1'b0;
            crc_wait_q  <= 1'b0;
            crc_q       <= 8'h00;
            pkt_type_q  <= 4'd0;
            byte_cnt_q  <= 4'd0;
            sop_err_q   <= 1'b0;
            crc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_base_q   <= in_base_d;
            out_base_q  <= out_base_d;
            chk_en_q    <= chk_en_d;
            cnt_q       <= cnt_d;
            wr_idx_q    <= wr_idx_d;
            data_pend_q <= data_pend_d;
            crc_wait_q  <= crc_wait_d;
            crc_q       <= crc_d;
            pkt_type_q  <= pkt_type_d;
            byte_cnt_q  <= byte_cnt_d;
            sop_err_q   <= sop_err_d;
            crc_err_q   <= crc_err_d;
        end
    end

    assign pp_busy     = (state_q != StIdle);
    assign pp_irq      = (state_q == StDone);
    assign pp_pkt_type = pkt_type_q;
    assign pp_byte_cnt = byte_cnt_q;
    assign pp_sop_err  = sop_err_q;
    assign pp_crc_err  = crc_err_q;
    assign pp_crc_calc = crc_q;

endmodule

// File: tb/tb_packet_parser.sv
// Self-checking bench for packet_parser: byte-wide source memory model and a
// scoreboard of expected destination writes.
module tb_packet_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic        pp_start;
    logic [31:0] pp_addr_in;
    logic [31:0] pp_addr_out;
    logic        pp_crc_chk_en;
    logic [31:0] src_addr;
    logic [31:0] src_data_o;
    logic [31:0] dst_addr;
    logic [31:0] dst_data_i;
    logic        dst_we;
    logic        pp_busy;
    logic        pp_irq;
    logic [3:0]  pp_pkt_type;
    logic [3:0]  pp_byte_cnt;
    logic        pp_sop_err;
    logic        pp_crc_err;
    logic [7:0]  pp_crc_calc;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] src_mem [256];
    logic [7:0] pkt_data [16];
    int         total = 0;
    int         bad = 0;

    packet_parser dut (
        .clk          (clk),
        .reset        (reset),
        .pp_start     (pp_start),
        .pp_addr_in   (pp_addr_in),
        .pp_addr_out  (pp_addr_out),
        .pp_crc_chk_en(pp_crc_chk_en),
        .src_addr     (src_addr),
        .src_data_o   (src_data_o),
        .dst_addr     (dst_addr),
        .dst_data_i   (dst_data_i),
        .dst_we       (dst_we),
        .pp_busy      (pp_busy),
        .pp_irq       (pp_irq),
        .pp_pkt_type  (pp_pkt_type),
        .pp_byte_cnt  (pp_byte_cnt),
        .pp_sop_err   (pp_sop_err),
        .pp_crc_err   (pp_crc_err),
        .pp_crc_calc  (pp_crc_calc)
    );

    always #5 clk = ~clk;

    // Upper bits carry junk so the DUT must use only the low byte.
    always @(posedge clk) src_data_o <= {24'h5A5A5A, src_mem[src_addr[7:0]]};

    function automatic logic [7:0] crc8_model(input int n);
        logic [7:0] c = 8'h00;
        for (int k = 0; k < n; k++) begin
            c = c ^ pkt_data[k];
            for (int b = 0; b < 8; b++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [116:0] all_outs();
        return {src_addr, dst_addr, dst_data_i, dst_we, pp_busy, pp_irq, pp_pkt_type,
                pp_byte_cnt, pp_sop_err, pp_crc_err, pp_crc_calc};
    endfunction

    task automatic load_pkt(input logic [31:0] ain, input logic [7:0] h0, input logic [7:0] h1,
                            input logic [7:0] crcb);
        logic [31:0] a;
        int          bc;
        bc = int'(h1[3:0]);
        a = ain;            src_mem[a[7:0]] = h0;
        a = ain + 32'd1;    src_mem[a[7:0]] = h1;
        for (int k = 0; k <= bc; k++) begin
            a = ain + 32'(k + 2);
            src_mem[a[7:0]] = pkt_data[k];
        end
        a = ain + 32'(bc + 3);
        src_mem[a[7:0]] = crcb;
    endtask

    task automatic run_pkt(input logic [31:0] ain, input logic [31:0] aout, input logic chk,
                           input int bc, input int restart_at, output int irq_at);
        wr_t e;
        for (int k = 0; k <= bc; k++) begin
            e.addr = aout + 32'(k);
            e.data = pkt_data[k];
            exp_q.push_back(e);
        end
        irq_at = -1;
        @(negedge clk);
        pp_addr_in = ain;
        pp_addr_out = aout;
        pp_crc_chk_en = chk;
        pp_start = 1'b1;
        for (int k = 1; k <= bc + 12; k++) begin
            @(negedge clk);
            pp_start = (k == restart_at);
            if (k == 1) begin
                pp_addr_in = ~ain;
                pp_addr_out = ~aout;
                pp_crc_chk_en = ~chk;
                total++;
                if (src_addr !== ain) begin
                    bad++;
                    $display("FAIL first_read src_addr=%h want %h", src_addr, ain);
                end
            end
            if (dst_we === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_write addr=%h data=%h want none", dst_addr, dst_data_i);
                end else begin
                    e = exp_q.pop_front();
                    if ({dst_addr, dst_data_i} !== {e.addr, 24'd0, e.data}) begin
                        bad++;
                        $display("FAIL write addr=%h data=%h want addr=%h data=%h",
                                 dst_addr, dst_data_i, e.addr, {24'd0, e.data});
                    end
                end
            end
            if (pp_irq === 1'b1) begin
                irq_at = k;
                break;
            end
        end
        pp_start = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_writes left=%0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
        reset = 1'b0;
        pp_start = 1'b0;
        pp_addr_in = 32'd0;
        pp_addr_out = 32'd0;
        pp_crc_chk_en = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (all_outs() !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want 0", all_outs());
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int irq_at;
        pkt_data[0] = 8'h01;
        load_pkt(32'h10, 8'hA3, 8'h00, 8'h07);
        run_pkt(32'h10, 32'h100, 1'b1, 0, 0, irq_at);
        total++;
        if (irq_at !== 6) begin
            bad++;
            $display("FAIL basic_irq_cycle got=%0d want 6", irq_at);
        end
        total++;
        if ({pp_busy, pp_pkt_type, pp_byte_cnt, pp_sop_err, pp_crc_err, pp_crc_calc} !==
            {1'b1, 4'h3, 4'h0, 1'b0, 1'b0, 8'h07}) begin
            bad++;
            $display("FAIL basic_fields busy/type/cnt/sop/crc/calc=%b/%h/%h/%b/%b/%h want 1/3/0/0/0/07",
                     pp_busy, pp_pkt_type, pp_byte_cnt, pp_sop_err, pp_crc_err, pp_crc_calc);
        end
        @(negedge clk);
        total++;
        if ({pp_busy, pp_irq, dst_we, src_addr} !== 35'd0) begin
            bad++;
            $display("FAIL basic_after_irq busy=%b irq=%b we=%b src=%h want 0",
                     pp_busy, pp_irq, dst_we, src_addr);
        end
    endtask

    task automatic test_crc_err();
        int irq_at;
        pkt_data[0] = 8'h01;
        load_pkt(32'h30, 8'hA3, 8'h00, 8'h08);
        run_pkt(32'h30, 32'h200, 1'b1, 0, 0, irq_at);
        total++;
        if ({pp_crc_err, pp_sop_err, pp_crc_calc} !== {1'b1, 1'b0, 8'h07} || irq_at !== 6) begin
            bad++;
            $display("FAIL crc_err_on crc_err=%b sop=%b calc=%h irq=%0d want 1/0/07/6",
                     pp_crc_err, pp_sop_err, pp_crc_calc, irq_at);
        end
        run_pkt(32'h30, 32'h200, 1'b0, 0, 0, irq_at);
        total++;
        if ({pp_crc_err, pp_crc_calc} !== {1'b0, 8'h07} || irq_at !== 6) begin
            bad++;
            $display("FAIL crc_err_off crc_err=%b calc=%h irq=%0d want 0/07/6",
                     pp_crc_err, pp_crc_calc, irq_at);
        end
    endtask

    task automatic test_sop_long();
        int irq_at;
        for (int k = 0; k < 16; k++) pkt_data[k] = 8'h00;
        load_pkt(32'h40, 8'h51, 8'h0F, 8'h00);
        run_pkt(32'h40, 32'h300, 1'b1, 15, 0, irq_at);
        total++;
        if (irq_at !== 21) begin
            bad++;
            $display("FAIL sop_long_irq_cycle got=%0d want 21", irq_at);
        end
        total++;
        if ({pp_pkt_type, pp_byte_cnt, pp_sop_err, pp_crc_err, pp_crc_calc} !==
            {4'h1, 4'hF, 1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL sop_long_fields type/cnt/sop/crc/calc=%h/%h/%b/%b/%h want 1/f/1/0/00",
                     pp_pkt_type, pp_byte_cnt, pp_sop_err, pp_crc_err, pp_crc_calc);
        end
    endtask

    task automatic test_wrap();
        int         irq_at;
        logic [7:0] c;
        for (int k = 0; k < 4; k++) pkt_data[k] = 8'($urandom_range(0, 255));
        c = crc8_model(4);
        load_pkt(32'hFFFF_FFFC, 8'hA9, 8'h03, c);
        run_pkt(32'hFFFF_FFFC, 32'hFFFF_FFFE, 1'b1, 3, 0, irq_at);
        total++;
        if ({pp_crc_calc, pp_crc_err, pp_sop_err, pp_byte_cnt} !== {c, 1'b0, 1'b0, 4'h3} ||
            irq_at !== 9) begin
            bad++;
            $display("FAIL wrap calc=%h crc_err=%b sop=%b cnt=%h irq=%0d want %h/0/0/3/9",
                     pp_crc_calc, pp_crc_err, pp_sop_err, pp_byte_cnt, irq_at, c);
        end
    endtask

    task automatic test_back_to_back();
        int         irq_at, irqs;
        logic [7:0] c;
        for (int k = 0; k < 6; k++) pkt_data[k] = 8'(8'h11 * (k + 1));
        c = crc8_model(6);
        load_pkt(32'h60, 8'hA7, 8'h05, c);
        run_pkt(32'h60, 32'h400, 1'b1, 5, 5, irq_at);
        total++;
        if (irq_at !== 11 || pp_crc_calc !== c || pp_crc_err !== 1'b0) begin
            bad++;
            $display("FAIL restart_ignored irq=%0d calc=%h crc_err=%b want 11/%h/0",
                     irq_at, pp_crc_calc, pp_crc_err, c);
        end
        irqs = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (pp_irq === 1'b1 || pp_busy === 1'b1 || dst_we === 1'b1) irqs++;
        end
        total++;
        if (irqs !== 0) begin
            bad++;
            $display("FAIL single_irq extra_active_cycles=%0d want 0", irqs);
        end
    endtask

    task automatic test_reset_mid();
        int         irq_at, act;
        logic [7:0] c;
        for (int k = 0; k < 8; k++) pkt_data[k] = 8'(3 * k + 1);
        c = crc8_model(8);
        load_pkt(32'h80, 8'hA2, 8'h07, c);
        @(negedge clk);
        pp_addr_in = 32'h80;
        pp_addr_out = 32'h500;
        pp_crc_chk_en = 1'b1;
        pp_start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            pp_start = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        total++;
        if (all_outs() !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h want 0", all_outs());
        end
        act = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (pp_irq === 1'b1 || dst_we === 1'b1 || src_addr !== 32'd0) act++;
        end
        total++;
        if (act !== 0) begin
            bad++;
            $display("FAIL mid_reset_quiet active_cycles=%0d want 0", act);
        end
        pkt_data[0] = 8'hFF;
        load_pkt(32'h20, 8'hA1, 8'h00, 8'hF3);
        run_pkt(32'h20, 32'h600, 1'b1, 0, 0, irq_at);
        total++;
        if ({pp_crc_calc, pp_crc_err, pp_sop_err, pp_pkt_type} !== {8'hF3, 1'b0, 1'b0, 4'h1} ||
            irq_at !== 6) begin
            bad++;
            $display("FAIL restart_after_reset calc=%h crc_err=%b sop=%b type=%h irq=%0d want f3/0/0/1/6",
                     pp_crc_calc, pp_crc_err, pp_sop_err, pp_pkt_type, irq_at);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc_err();
        test_sop_long();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_parser.md
PACKET_PARSER -- requirements
Module: packet_parser

Interface
REQ-001 Parameter SOP_VAL, default 4'hA: expected start-of-packet nibble.
REQ-002 Parameter CRC_POLY, default 8'h07: CRC-8 polynomial.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-low; reset asserted when 0, sampled on rising clk.
REQ-005 pp_start  input  1  one-cycle start pulse.
REQ-006 pp_addr_in  input  32  byte address of packet header in source memory.
REQ-007 pp_addr_out  input  32  byte address of first extracted data byte in destination memory.
REQ-008 pp_crc_chk_en  input  1  1 = compare CRC; 0 = never flag CRC error.
REQ-009 src_addr  output  32  source-memory byte read address.
REQ-010 src_data_o  input  32  source read data; byte in [7:0], valid one cycle after src_addr.
REQ-011 dst_addr  output  32  destination byte write address.
REQ-012 dst_data_i  output  32  write data; byte in [7:0], [31:8] = 0.
REQ-013 dst_we  output  1  destination write enable.
REQ-014 pp_busy  output  1  high from cycle after accepted start until irq cycle inclusive.
REQ-015 pp_irq  output  1  one-cycle completion pulse.
REQ-016 pp_pkt_type, pp_byte_cnt  output  4 each  header fields, valid from irq onward.
REQ-017 pp_sop_err, pp_crc_err  output  1 each  error flags, valid from irq until next accepted start.
REQ-018 pp_crc_calc  output  8  CRC computed over data bytes.

Function
REQ-019 Packet format, byte offsets from pp_addr_in: 0 = {sop[7:4], pkt_type[3:0]}; 1 = {ecc[7:4], byte_cnt[3:0]}; 2..byte_cnt+2 = data (byte_cnt+1 bytes); byte_cnt+3 = CRC.
REQ-020 FSM states: IDLE, RD_HDR0, RD_HDR1, RD_DATA, RD_CRC, DONE.
REQ-021 IDLE: pp_start latches pp_addr_in, pp_addr_out, pp_crc_chk_en; next state RD_HDR0. pp_start outside IDLE is ignored.
REQ-022 Reads issue back-to-back, one byte per cycle: offset 0 in RD_HDR0, 1 in RD_HDR1, 2..byte_cnt+2 in RD_DATA, byte_cnt+3 in RD_CRC.
REQ-023 byte_cnt is captured from returned header byte 1 in the first RD_DATA cycle; a 4-bit data counter terminates RD_DATA after byte_cnt+1 reads.
REQ-024 Data byte k (0-based) returned in cycle t is written to pp_addr_out+k with dst_we=1 in cycle t; at most one write per cycle.
REQ-025 CRC: MSB-first, init 8'h00, no reflection, no final XOR, over data bytes only, one byte per cycle; the accumulator clears on accepted start.
REQ-026 DONE is entered the cycle the CRC byte returns; pp_irq=1 for exactly that cycle, then IDLE.
REQ-027 pp_crc_err = pp_crc_chk_en & (received CRC != pp_crc_calc); pp_sop_err = (header byte0[7:4] != SOP_VAL).
REQ-028 A SOP error does not abort: all data is written, CRC is checked, and irq is raised.
REQ-029 Latency: start at cycle 0 gives first read at cycle 1 and irq at cycle byte_cnt+6; the total packet length is byte_cnt+4 bytes.
REQ-030 Address arithmetic is 32-bit modulo 2^32; wrap-around is legal and unflagged.
REQ-031 src_addr and dst_addr are 0 when not in an active read/write cycle; dst_we is never high in IDLE.

Reset
REQ-032 On reset=0, the FSM goes to IDLE and all outputs go to 0, including pp_crc_calc=8'h00.
REQ-033 Reset mid-packet: no further reads or writes, no irq, flags cleared; the next start is processed normally.

Structure
REQ-034 Shared package pp_pkg holds the FSM state enum, header byte offsets, SOP_VAL and CRC_POLY defaults.
REQ-035 One sub-module, crc8_byte_step: combinational (crc_in, data_in) -> crc_out, parameterised by CRC_POLY.

Verification
REQ-036 Header 0xA3,0x00; data 0x01; CRC 0x07 -> one write 0x01 @ pp_addr_out; pkt_type=3; byte_cnt=0; crc_calc=0x07; no errors; irq at cycle 6.
REQ-037 Same packet with CRC byte 0x08 and pp_crc_chk_en=1 -> pp_crc_err=1; with pp_crc_chk_en=0 -> pp_crc_err=0.
REQ-038 Header 0x51,0x0F; 16 data bytes 0x00; CRC 0x00 -> sop_err=1, 16 writes, crc_calc=0x00, irq at cycle 21.
REQ-039 pp_addr_out=32'hFFFF_FFFE, 4 data bytes -> writes to FFFF_FFFE, FFFF_FFFF, 0, 1.
REQ-040 pp_start repeated during RD_DATA -> ignored, exactly one irq; reset=0 asserted in RD_DATA -> outputs 0, no irq; restart with data 0xFF -> crc_calc=0xF3.
